// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the single-path delay-feedback FFT: clock enable, framing, zero-pad/drain, output tags.
// Define FFT_CTRL_BITREV_EN to emit bit-reversed reorder-buffer write addresses.
module fft_frame_ctrl #(
  parameter int N   = 3,
  parameter int LAT = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush_req,
  output logic         flush_done,
  input  logic         out_ready,
  output logic         fft_ce,
  output logic         fft_start,
  output logic         fft_zero,
  output logic         out_valid,
  output logic         out_start,
  output logic [N-1:0] out_addr,
  output logic         frame_done,
  output logic         busy
);

  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [1:0] {ACTIVE, PAD, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   in_cnt, in_cnt_nxt;
  logic [N-1:0]   out_cnt, out_cnt_nxt, out_idx;
  logic [DW-1:0]  dcnt, dcnt_nxt;
  logic [LAT-1:0] real_pipe, sop_pipe;
  logic           flush_done_q, flush_done_nxt;
  logic           real_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACTIVE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      dcnt         <= '0;
      real_pipe    <= '0;
      sop_pipe     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_cnt       <= in_cnt_nxt;
      out_cnt      <= out_cnt_nxt;
      dcnt         <= dcnt_nxt;
      flush_done_q <= flush_done_nxt;
      if (fft_ce) begin
        real_pipe <= (real_pipe << 1) | LAT'(real_in);
        sop_pipe  <= (sop_pipe << 1) | LAT'(fft_start);
      end
    end
  end

  // A flush decides between padding and draining on the post-update input count.
  always_comb begin
    state_nxt      = state;
    dcnt_nxt       = dcnt;
    flush_done_nxt = 1'b0;
    in_cnt_nxt     = (fft_ce && state != DRAIN) ? in_cnt + 1'b1 : in_cnt;
    out_cnt_nxt    = out_valid ? out_idx + 1'b1 : out_cnt;
    case (state)
      ACTIVE: begin
        if (flush_req) begin
          dcnt_nxt  = '0;
          state_nxt = (in_cnt_nxt == '0) ? DRAIN : PAD;
        end
      end
      PAD: begin
        if (fft_ce && in_cnt_nxt == '0) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        if (fft_ce) begin
          if (dcnt == DW'(LAT - 1)) begin
            state_nxt      = ACTIVE;
            dcnt_nxt       = '0;
            flush_done_nxt = 1'b1;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  always_comb begin
    fft_ce     = (state == ACTIVE) ? (in_valid && out_ready) : out_ready;
    in_ready   = out_ready && (state == ACTIVE);
    fft_zero   = (state != ACTIVE);
    fft_start  = fft_ce && (in_cnt == '0) && (state != DRAIN);
    real_in    = (state != DRAIN);
    out_valid  = fft_ce && real_pipe[LAT-1];
    out_start  = fft_ce && sop_pipe[LAT-1];
    out_idx    = out_start ? '0 : out_cnt;
    frame_done = out_valid && (out_cnt == '1);
    busy       = (|real_pipe) || (state != ACTIVE);
    flush_done = flush_done_q;
    out_addr   = '0;
`ifdef FFT_CTRL_BITREV_EN
    for (int i = 0; i < N; i++) out_addr[i] = out_idx[N-1-i];
`else
    out_addr   = out_idx;
`endif
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fft_frame_ctrl;
  localparam int N  = 3;
  localparam int LAT = 7;
  localparam int FS = 8;
  localparam int M_ACTIVE = 0, M_PAD = 1, M_DRAIN = 2;
`ifdef FFT_CTRL_BITREV_EN
  localparam logic [23:0] EXP_SEQ = 24'o04261537;
`else
  localparam logic [23:0] EXP_SEQ = 24'o01234567;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush_req = 1'b0, out_ready = 1'b0;
  logic in_ready, flush_done, fft_ce, fft_start, fft_zero;
  logic out_valid, out_start, frame_done, busy;
  logic [N-1:0] out_addr;

  fft_frame_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush_req(flush_req), .flush_done(flush_done), .out_ready(out_ready),
    .fft_ce(fft_ce), .fft_start(fft_start), .fft_zero(fft_zero),
    .out_valid(out_valid), .out_start(out_start), .out_addr(out_addr),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  // Reference model: controller mode, frame fill level, drain progress and a
  // history of the tags entered on the last LAT enabled cycles.
  int m_mode, m_fill, m_drained, m_outidx;
  bit m_fd, pend;
  bit [1:0] m_q[$];
  bit e_ce, e_ir, e_start, e_zero, e_ov, e_os, e_done, e_busy;
  int e_idx;
  logic [11:0] exp_vec, act_vec;

  // Per-scenario tallies of what the DUT emitted.
  int s_ov, s_done, s_fd, s_zero_ce, s_ce, s_first_ov;
  logic [23:0] s_seq;
  logic [N-1:0] s_done_addr;

  function automatic logic [N-1:0] addr_of(int idx);
    int r;
    r = idx;
`ifdef FFT_CTRL_BITREV_EN
    r = 0;
    for (int i = 0; i < N; i++) r = r * 2 + ((idx >> i) & 1);
`endif
    return r[N-1:0];
  endfunction

  function automatic logic [11:0] dut_vec();
    return {fft_ce, in_ready, fft_start, fft_zero, out_valid, out_start,
            out_addr, frame_done, busy, flush_done};
  endfunction

  task automatic model_reset();
    m_mode = M_ACTIVE; m_fill = 0; m_drained = 0; m_outidx = 0;
    m_fd = 0; pend = 0;
    m_q.delete();
  endtask

  task automatic model_eval();
    e_ce    = (m_mode == M_ACTIVE) ? (in_valid && out_ready) : out_ready;
    e_ir    = out_ready && (m_mode == M_ACTIVE);
    e_zero  = (m_mode != M_ACTIVE);
    e_start = e_ce && (m_fill == 0) && (m_mode != M_DRAIN);
    e_ov = 0; e_os = 0;
    if (e_ce && m_q.size() == LAT) begin
      e_ov = m_q[0][1];
      e_os = m_q[0][0];
    end
    e_idx  = e_os ? 0 : m_outidx;
    e_done = e_ov && (e_idx == FS - 1);
    e_busy = (m_mode != M_ACTIVE);
    foreach (m_q[i]) if (m_q[i][1]) e_busy = 1;
    exp_vec = {e_ce, e_ir, e_start, e_zero, e_ov, e_os, addr_of(e_idx),
               e_done, e_busy, m_fd};
    pend = 1;
  endtask

  task automatic model_commit();
    int new_fill;
    if (e_ov) m_outidx = (e_idx + 1) % FS;
    new_fill = (e_ce && m_mode != M_DRAIN) ? (m_fill + 1) % FS : m_fill;
    if (e_ce) begin
      m_q.push_back({m_mode != M_DRAIN, e_start});
      if (m_q.size() > LAT) void'(m_q.pop_front());
    end
    m_fd = 0;
    case (m_mode)
      M_ACTIVE: if (flush_req) begin
        m_mode = (new_fill == 0) ? M_DRAIN : M_PAD;
        m_drained = 0;
      end
      M_PAD: if (e_ce && new_fill == 0) begin
        m_mode = M_DRAIN;
        m_drained = 0;
      end
      default: if (e_ce) begin
        m_drained++;
        if (m_drained == LAT) begin
          m_mode = M_ACTIVE;
          m_fd = 1;
        end
      end
    endcase
    m_fill = new_fill;
    pend = 0;
  endtask

  task automatic clear_tally();
    s_ov = 0; s_done = 0; s_fd = 0; s_zero_ce = 0; s_ce = 0;
    s_first_ov = -1; s_seq = '0; s_done_addr = '0;
  endtask

  // One clock cycle: drive inputs at the falling edge, settle, predict and sample.
  task automatic step(input bit iv, input bit ordy, input bit fl);
    @(negedge clk);
    if (pend) model_commit();
    in_valid = iv; out_ready = ordy; flush_req = fl;
    #1;
    model_eval();
    act_vec = dut_vec();
    if (out_valid) begin
      if (s_first_ov < 0) s_first_ov = s_ce;
      s_ov++;
      s_seq = {s_seq[20:0], out_addr};
    end
    if (frame_done) begin s_done++; s_done_addr = out_addr; end
    if (flush_done) s_fd++;
    if (fft_ce && fft_zero) s_zero_ce++;
    if (fft_ce) s_ce++;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush_req = 0;
    rst_n = 0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    hold_reset();
    total++; if (dut_vec() !== 12'h0) $display("[TB] FAIL reset_outputs: got %b want 0", dut_vec()); else passed++;
    @(posedge clk); #1;
    total++; if (dut_vec() !== 12'h0) $display("[TB] FAIL reset_hold: got %b want 0", dut_vec()); else passed++;
    release_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL reset_idle c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
    end
  endtask

  task automatic test_full_frame();
    clear_tally();
    for (int i = 0; i < FS; i++) begin
      step(1, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL full_frame c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
      if (i == 0) begin
        total++; if (fft_start !== 1'b1) $display("[TB] FAIL full_first_start: got %b want 1", fft_start); else passed++;
      end
    end
    step(0, 1, 1);
    total++; if (act_vec !== exp_vec) $display("[TB] FAIL full_flush: got %b want %b", act_vec, exp_vec); else passed++;
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL full_drain c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_fd !== 1) $display("[TB] FAIL full_flush_done: got %0d want 1", s_fd); else passed++;
    total++; if (s_ov !== FS) $display("[TB] FAIL full_ov_count: got %0d want %0d", s_ov, FS); else passed++;
    total++; if (s_first_ov !== LAT) $display("[TB] FAIL full_latency: got %0d want %0d", s_first_ov, LAT); else passed++;
    total++; if (s_seq !== EXP_SEQ) $display("[TB] FAIL full_addr_seq: got %o want %o", s_seq, EXP_SEQ); else passed++;
    total++; if (s_done !== 1 || s_done_addr !== 3'd7) $display("[TB] FAIL full_frame_done: got %0d@%0d want 1@7", s_done, s_done_addr); else passed++;
    total++; if (s_zero_ce !== LAT) $display("[TB] FAIL full_drain_len: got %0d want %0d", s_zero_ce, LAT); else passed++;
  endtask

  task automatic test_valid_toggle();
    clear_tally();
    for (int i = 0; i < 2 * FS; i++) begin
      step(i % 2 == 0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL toggle c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
      total++; if (fft_ce !== (i % 2 == 0)) $display("[TB] FAIL toggle_ce c%0d: got %b want %b", i, fft_ce, i % 2 == 0); else passed++;
    end
    step(0, 1, 1);
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL toggle_drain c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_ov !== FS) $display("[TB] FAIL toggle_ov_count: got %0d want %0d", s_ov, FS); else passed++;
    total++; if (s_seq !== EXP_SEQ) $display("[TB] FAIL toggle_addr_seq: got %o want %o", s_seq, EXP_SEQ); else passed++;
  endtask

  task automatic test_stall();
    clear_tally();
    for (int i = 0; i < 12; i++) begin
      step(1, !(i >= 4 && i < 8), 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL stall c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
      if (i >= 4 && i < 8) begin
        total++; if ({in_ready, fft_ce} !== 2'b00) $display("[TB] FAIL stall_hold c%0d: got %b want 00", i, {in_ready, fft_ce}); else passed++;
      end
    end
    step(0, 1, 1);
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL stall_drain c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_ov !== FS) $display("[TB] FAIL stall_ov_count: got %0d want %0d", s_ov, FS); else passed++;
    total++; if (s_seq !== EXP_SEQ) $display("[TB] FAIL stall_addr_seq: got %o want %o", s_seq, EXP_SEQ); else passed++;
  endtask

  task automatic test_partial_flush();
    clear_tally();
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(0, 1, 1);
    total++; if (act_vec !== exp_vec) $display("[TB] FAIL partial_flush: got %b want %b", act_vec, exp_vec); else passed++;
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL partial c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_zero_ce !== FS - 3 + LAT) $display("[TB] FAIL partial_zero_cycles: got %0d want %0d", s_zero_ce, FS - 3 + LAT); else passed++;
    total++; if (s_ov !== FS) $display("[TB] FAIL partial_ov_count: got %0d want %0d", s_ov, FS); else passed++;
    total++; if (s_done !== 1) $display("[TB] FAIL partial_frame_done: got %0d want 1", s_done); else passed++;
    total++; if (s_fd !== 1) $display("[TB] FAIL partial_flush_done: got %0d want 1", s_fd); else passed++;
  endtask

  task automatic test_mid_reset();
    clear_tally();
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    hold_reset();
    total++; if (dut_vec() !== 12'h0) $display("[TB] FAIL midreset_outputs: got %b want 0", dut_vec()); else passed++;
    release_reset();
    clear_tally();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL midreset_idle c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
    end
    total++; if (s_ov !== 0) $display("[TB] FAIL midreset_stale_ov: got %0d want 0", s_ov); else passed++;
    for (int i = 0; i < FS; i++) begin
      step(1, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL midreset_feed c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
    end
    step(0, 1, 1);
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL midreset_drain c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_ov !== FS) $display("[TB] FAIL midreset_ov_count: got %0d want %0d", s_ov, FS); else passed++;
    total++; if (s_first_ov !== LAT) $display("[TB] FAIL midreset_latency: got %0d want %0d", s_first_ov, LAT); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 40) == 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL random c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL random_settle c%0d: got %b want %b", i, act_vec, exp_vec); else passed++;
    end
    clear_tally();
    step(0, 1, 1);
    for (int k = 0; k < 60 && s_fd == 0; k++) begin
      step(0, 1, 0);
      total++; if (act_vec !== exp_vec) $display("[TB] FAIL random_drain c%0d: got %b want %b", k, act_vec, exp_vec); else passed++;
    end
    total++; if (s_fd !== 1) $display("[TB] FAIL random_flush_done: got %0d want 1", s_fd); else passed++;
    step(0, 0, 0);
    total++; if (busy !== 1'b0) $display("[TB] FAIL random_idle_busy: got %b want 0", busy); else passed++;
  endtask

  initial begin
    model_reset();
    clear_tally();
    test_reset();
    test_full_frame();
    test_valid_toggle();
    test_stall();
    test_partial_flush();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
